// File: rtl/axil_cmd_master_if.sv
// axil_cmd_master_if: command/response stream plus AXI4-Lite master bus of axil_cmd_master.
interface axil_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_write;
    logic        rsp_timeout;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_timeout,
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        output axi_araddr, axi_arvalid, axi_rready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp, axi_rvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_write, rsp_timeout,
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
        input  axi_araddr, axi_arvalid, axi_rready
    );
endinterface

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding AXI4-Lite initiator fed by a command/response stream.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to enable the hung-slave watchdog (TIMEOUT_CYCLES).
module axil_cmd_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               aclk,
    input logic               aresetn,
    axil_cmd_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;
    state_t state, state_n;
    logic aw_done, w_done, accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, busy, tmo;

    assign bus.cmd_ready  = state == IDLE;
    assign bus.axi_bready = state == WR_RESP;
    assign bus.axi_rready = state == RD_DATA;
    assign accept = bus.cmd_valid && state == IDLE;
    assign aw_hs  = bus.axi_awvalid && bus.axi_awready;
    assign w_hs   = bus.axi_wvalid && bus.axi_wready;
    assign ar_hs  = bus.axi_arvalid && bus.axi_arready;
    assign b_hs   = bus.axi_bready && bus.axi_bvalid;
    assign r_hs   = bus.axi_rready && bus.axi_rvalid;
    assign busy   = state inside {WR_REQ, WR_RESP, RD_REQ, RD_DATA};

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;
    logic        timeout_q;
    // A real slave response in the final cycle wins over the watchdog
    assign tmo = busy && cnt == TMO_LAST && !b_hs && !r_hs;
    assign bus.rsp_timeout = timeout_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt       <= accept ? '0 : busy ? cnt + 16'd1 : cnt;
            timeout_q <= tmo ? 1'b1 : (b_hs || r_hs) ? 1'b0 : timeout_q;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout  = TIMEOUT_CYCLES;
    assign tmo             = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.cmd_valid) state_n = bus.cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WR_RESP;
            WR_RESP: if (b_hs) state_n = RSP;
            RD_REQ:  if (ar_hs) state_n = RD_DATA;
            RD_DATA: if (r_hs) state_n = RSP;
            RSP:     if (bus.rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (tmo) state_n = RSP;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            bus.axi_awaddr  <= '0;
            bus.axi_awvalid <= 1'b0;
            bus.axi_wdata   <= '0;
            bus.axi_wstrb   <= '0;
            bus.axi_wvalid  <= 1'b0;
            bus.axi_araddr  <= '0;
            bus.axi_arvalid <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_resp    <= '0;
            bus.rsp_write   <= 1'b0;
        end else begin
            if (accept) begin
                bus.rsp_write <= bus.cmd_write;
                if (bus.cmd_write) begin
                    bus.axi_awaddr <= {bus.cmd_addr[31:2], 2'b00};
                    bus.axi_wdata  <= bus.cmd_wdata;
                    bus.axi_wstrb  <= bus.cmd_wstrb;
                end else begin
                    bus.axi_araddr <= {bus.cmd_addr[31:2], 2'b00};
                end
            end
            aw_done         <= !accept && (aw_done || aw_hs);
            w_done          <= !accept && (w_done || w_hs);
            bus.axi_awvalid <= !tmo && (accept ? bus.cmd_write : bus.axi_awvalid && !bus.axi_awready);
            bus.axi_wvalid  <= !tmo && (accept ? bus.cmd_write : bus.axi_wvalid && !bus.axi_wready);
            bus.axi_arvalid <= !tmo && (accept ? !bus.cmd_write : bus.axi_arvalid && !bus.axi_arready);
            bus.rsp_valid   <= state_n == RSP;
            if (tmo) begin
                bus.rsp_resp  <= 2'b11;
                bus.rsp_rdata <= '0;
            end else if (b_hs) begin
                bus.rsp_resp  <= bus.axi_bresp;
                bus.rsp_rdata <= '0;
            end else if (r_hs) begin
                bus.rsp_resp  <= bus.axi_rresp;
                bus.rsp_rdata <= bus.axi_rdata;
            end
        end
    end
endmodule
